// File: rtl/user_bram_arbiter.sv
// ---------------------------------------------------------------------------
// user_bram_arbiter
//
// Shares one single-port user BRAM between two requesters:
//   * the management-SoC Wishbone slave port (byte window selected by
//     wbs_adr_i[31:24] == DECODE), and
//   * a local DMA-style master (req/ack handshake, word addressed).
//
// A three-state sequencer (IDLE -> ACCESS -> DONE -> IDLE) grants one
// requester, holds the BRAM enabled for a fixed window of DELAYS+1 cycles,
// captures the BRAM read data at the end of the window and returns a
// one-cycle acknowledge with that data to the granted requester.
//
// Contested grants alternate: when both request in IDLE, the requester that
// did not own the last access wins. Reset leaves owner at DMA so the first
// contested grant goes to Wishbone.
//
// Ports
//   wb_clk_i, wb_rst_n   clock, asynchronous active-low reset
//   wbs_*_i / wbs_*_o    Wishbone slave (cyc, stb, we, sel, adr, dat, ack)
//   dma_*_i / dma_*_o    local master (req, we, sel, word adr, dat, ack)
//   bram_*_o, bram_do_i  BRAM port 0 (EN0, WE0, A0 byte address, Di0, Do0)
//   busy_o               high whenever the sequencer is not IDLE
//   owner_o              current/last grant: 0 = Wishbone, 1 = DMA
// ---------------------------------------------------------------------------
module user_bram_arbiter #(
  parameter int          ADDR_W = 10,    // BRAM word-address width
  parameter int          DELAYS = 10,    // extra wait cycles in the window
  parameter logic [7:0]  DECODE = 8'h38  // wbs_adr_i[31:24] of the window
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  // Wishbone slave
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  // Local DMA master
  input  logic               dma_req_i,
  input  logic               dma_we_i,
  input  logic [3:0]         dma_sel_i,
  input  logic [ADDR_W-1:0]  dma_adr_i,
  input  logic [31:0]        dma_dat_i,
  output logic               dma_ack_o,
  output logic [31:0]        dma_dat_o,
  // BRAM port 0
  output logic               bram_en_o,
  output logic [3:0]         bram_we_o,
  output logic [31:0]        bram_a_o,
  output logic [31:0]        bram_di_o,
  input  logic [31:0]        bram_do_i,
  // Status
  output logic               busy_o,
  output logic               owner_o
);

  // -------------------------------------------------------------------------
  // Constants
  // -------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam logic OWN_WB  = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  // Window counter runs 0..DELAYS; keep at least one bit for DELAYS = 0.
  localparam int                CNT_W    = (DELAYS < 1) ? 1 : $clog2(DELAYS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DELAYS);

  // Zero padding above the word address in the BRAM byte address.
  localparam int A_PAD = 32 - ADDR_W - 2;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]         state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               owner_q,   owner_d;
  logic               we_q,      we_d;
  logic [3:0]         sel_q,     sel_d;
  logic [ADDR_W-1:0]  addr_q,    addr_d;
  logic [31:0]        wdata_q,   wdata_d;
  logic               wbs_ack_q, wbs_ack_d;
  logic               dma_ack_q, dma_ack_d;
  logic [31:0]        wbs_dat_q, wbs_dat_d;
  logic [31:0]        dma_dat_q, dma_dat_d;

  // -------------------------------------------------------------------------
  // Request decode and arbitration
  // -------------------------------------------------------------------------
  logic wb_req;
  logic grant_dma;
  logic in_access;
  logic wb_abort;
  logic window_end;

  assign wb_req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == DECODE);

  // Lone requester always wins; on contention the last owner yields.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned -- an unassigned path would infer a latch.
    grant_dma = 1'b0;
    if (dma_req_i && !wb_req) begin
      grant_dma = 1'b1;
    end else if (dma_req_i && wb_req) begin
      grant_dma = (owner_q == OWN_WB);
    end
  end

  assign in_access  = (state_q == ST_ACCESS);
  // Only a Wishbone owner can walk away mid-window; the DMA master holds req.
  assign wb_abort   = in_access & (owner_q == OWN_WB) & ~wbs_cyc_i;
  assign window_end = in_access & (cnt_q == CNT_LAST);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    we_d      = we_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    // Acks and read data are pulses: zero unless the window closes now.
    wbs_ack_d = 1'b0;
    dma_ack_d = 1'b0;
    wbs_dat_d = '0;
    dma_dat_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (wb_req || dma_req_i) begin
          owner_d = grant_dma ? OWN_DMA : OWN_WB;
          if (grant_dma) begin
            we_d    = dma_we_i;
            sel_d   = dma_sel_i;
            addr_d  = dma_adr_i;
            wdata_d = dma_dat_i;
          end else begin
            we_d    = wbs_we_i;
            sel_d   = wbs_sel_i;
            // Byte address -> word address; upper bits wrap inside the BRAM.
            addr_d  = wbs_adr_i[ADDR_W+1:2];
            wdata_d = wbs_dat_i;
          end
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (wb_abort) begin
          // Abandon without ack; read data is left untouched.
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (window_end) begin
          cnt_d   = '0;
          state_d = ST_DONE;
          if (owner_q == OWN_DMA) begin
            dma_ack_d = 1'b1;
            dma_dat_d = bram_do_i;
          end else begin
            wbs_ack_d = 1'b1;
            wbs_dat_d = bram_do_i;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      owner_q   <= OWN_DMA;
      we_q      <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wbs_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      wbs_dat_q <= '0;
      dma_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wbs_ack_q <= wbs_ack_d;
      dma_ack_q <= dma_ack_d;
      wbs_dat_q <= wbs_dat_d;
      dma_dat_q <= dma_dat_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // BRAM strobes are forced to zero outside the access window. A write
  // repeats on every window cycle, which is harmless for the same word.
  assign bram_en_o = in_access;
  assign bram_we_o = (in_access && we_q) ? sel_q : 4'b0000;
  assign bram_a_o  = in_access ? {{A_PAD{1'b0}}, addr_q, 2'b00} : 32'h0;
  assign bram_di_o = in_access ? wdata_q : 32'h0;

  assign wbs_ack_o = wbs_ack_q;
  assign wbs_dat_o = wbs_dat_q;
  assign dma_ack_o = dma_ack_q;
  assign dma_dat_o = dma_dat_q;

  assign busy_o    = (state_q != ST_IDLE);
  assign owner_o   = owner_q;

  // Only the decode byte and word-address bits of wbs_adr_i matter.
  logic unused_adr;
  assign unused_adr = ^wbs_adr_i;

endmodule

// File: tb/tb_user_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_user_bram_arbiter
//
// Drives user_bram_arbiter with directed scenarios followed by two
// independent randomized masters. A transaction-level model (grant time,
// window position, shadow memory) predicts every output; a compare process
// checks all outputs against it on every falling edge. Directed scenarios
// add hand-computed literal expectations. The bench also provides a simple
// BRAM: combinational read, byte-masked write on the rising edge.
// ---------------------------------------------------------------------------
module tb_user_bram_arbiter;

  localparam int         AW  = 10;
  localparam int         D   = 10;
  localparam logic [7:0] DEC = 8'h38;
  localparam int         DEPTH = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]    wbs_sel_i = '0;
  logic [31:0]   wbs_adr_i = '0, wbs_dat_i = '0;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic          dma_req_i = 1'b0, dma_we_i = 1'b0;
  logic [3:0]    dma_sel_i = '0;
  logic [AW-1:0] dma_adr_i = '0;
  logic [31:0]   dma_dat_i = '0;
  logic          dma_ack_o;
  logic [31:0]   dma_dat_o;
  logic          bram_en_o;
  logic [3:0]    bram_we_o;
  logic [31:0]   bram_a_o, bram_di_o, bram_do_i;
  logic          busy_o, owner_o;

  user_bram_arbiter #(.ADDR_W(AW), .DELAYS(D), .DECODE(DEC)) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .dma_req_i(dma_req_i),
    .dma_we_i (dma_we_i),
    .dma_sel_i(dma_sel_i),
    .dma_adr_i(dma_adr_i),
    .dma_dat_i(dma_dat_i),
    .dma_ack_o(dma_ack_o),
    .dma_dat_o(dma_dat_o),
    .bram_en_o(bram_en_o),
    .bram_we_o(bram_we_o),
    .bram_a_o (bram_a_o),
    .bram_di_o(bram_di_o),
    .bram_do_i(bram_do_i),
    .busy_o   (busy_o),
    .owner_o  (owner_o)
  );

  // ---------------------------------------------------------------- checking
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ bench BRAM
  logic [31:0] bram_mem [DEPTH];
  assign bram_do_i = bram_mem[bram_a_o[AW+1:2]];

  initial begin
    for (int i = 0; i < DEPTH; i++) bram_mem[i] = 32'h0;
    forever begin
      @(posedge clk);
      if (bram_en_o) begin
        for (int b = 0; b < 4; b++)
          if (bram_we_o[b]) bram_mem[bram_a_o[AW+1:2]][8*b +: 8] <= bram_di_o[8*b +: 8];
      end
    end
  end

  // ------------------------------------------------------------------ model
  // m_t counts cycles since the grant edge: 1..D+1 = window, D+2 = ack cycle.
  logic          m_active = 1'b0;
  int            m_t      = 0;
  logic          m_owner  = 1'b1;
  logic          m_we     = 1'b0;
  logic [3:0]    m_sel    = '0;
  logic [AW-1:0] m_word   = '0;
  logic [31:0]   m_data   = '0;
  logic [31:0]   m_rdata  = '0;
  logic [31:0]   model_mem [DEPTH];

  initial begin
    logic        wb_wants;
    logic        give_dma;
    logic [31:0] cap;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 1'b0;
        m_t      = 0;
        m_owner  = 1'b1;
      end else if (!m_active) begin
        wb_wants = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:24] == DEC);
        if (wb_wants || dma_req_i) begin
          if (wb_wants && dma_req_i) give_dma = ~m_owner;  // alternate
          else                       give_dma = dma_req_i;
          m_owner  = give_dma;
          m_active = 1'b1;
          m_t      = 1;
          if (give_dma) begin
            m_we = dma_we_i; m_sel = dma_sel_i; m_word = dma_adr_i; m_data = dma_dat_i;
          end else begin
            m_we = wbs_we_i; m_sel = wbs_sel_i; m_word = wbs_adr_i[AW+1:2]; m_data = wbs_dat_i;
          end
        end
      end else if (m_t <= D + 1) begin
        // Every window edge reads the word, then the write lands.
        cap = model_mem[m_word];
        if (m_we)
          for (int b = 0; b < 4; b++)
            if (m_sel[b]) model_mem[m_word][8*b +: 8] = m_data[8*b +: 8];
        if (!m_owner && !wbs_cyc_i) begin
          m_active = 1'b0;
          m_t      = 0;
        end else begin
          if (m_t == D + 1) m_rdata = cap;
          m_t++;
        end
      end else begin
        m_active = 1'b0;
        m_t      = 0;
      end
    end
  end

  // Compare every output against the model on every falling edge.
  logic cmp_en = 1'b0;
  initial begin
    logic acc, ack;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        acc = m_active && (m_t >= 1) && (m_t <= D + 1);
        ack = m_active && (m_t == D + 2);
        check("busy",     32'(busy_o),    32'(m_active));
        check("owner",    32'(owner_o),   32'(m_owner));
        check("bram_en",  32'(bram_en_o), 32'(acc));
        check("bram_we",  32'(bram_we_o), (acc && m_we) ? 32'(m_sel) : 32'h0);
        check("bram_a",   bram_a_o,       acc ? (32'(m_word) << 2) : 32'h0);
        check("bram_di",  bram_di_o,      acc ? m_data : 32'h0);
        check("wbs_ack",  32'(wbs_ack_o), 32'(ack && !m_owner));
        check("dma_ack",  32'(dma_ack_o), 32'(ack && m_owner));
        check("wbs_dat",  wbs_dat_o,      (ack && !m_owner) ? m_rdata : 32'h0);
        check("dma_dat",  dma_dat_o,      (ack && m_owner) ? m_rdata : 32'h0);
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic wb_set(input logic on, input logic [31:0] adr, input logic we,
                        input logic [3:0] sel, input logic [31:0] dat);
    wbs_cyc_i = on; wbs_stb_i = on; wbs_we_i = we;
    wbs_adr_i = adr; wbs_sel_i = sel; wbs_dat_i = dat;
  endtask

  task automatic dma_set(input logic on, input logic [AW-1:0] adr, input logic we,
                         input logic [3:0] sel, input logic [31:0] dat);
    dma_req_i = on; dma_we_i = we; dma_adr_i = adr; dma_sel_i = sel; dma_dat_i = dat;
  endtask

  // Wait (bounded) for the chosen ack; lat = falling edges waited.
  task automatic wait_ack(input logic is_dma, input int limit,
                          output int lat, output logic [31:0] rd);
    logic got;
    got = 1'b0; lat = 0; rd = '0;
    while (!got && lat < limit) begin
      @(negedge clk);
      lat++;
      if (is_dma ? dma_ack_o : wbs_ack_o) begin
        got = 1'b1;
        rd  = is_dma ? dma_dat_o : wbs_dat_o;
      end
    end
    if (!got) check(is_dma ? "dma_ack_timeout" : "wb_ack_timeout", 32'(got), 32'd1);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",   32'(busy_o),    32'd0);
    check("rst_owner",  32'(owner_o),   32'd1);
    check("rst_en",     32'(bram_en_o), 32'd0);
    check("rst_a",      bram_a_o,       32'h0);
    check("rst_dmaack", 32'(dma_ack_o), 32'd0);
    check("rst_wback",  32'(wbs_ack_o), 32'd0);
    #1 rst_n = 1'b1;
  endtask

  task automatic wb_random();
    logic [9:0]  word;
    logic [31:0] adr;
    logic        nd, abort, aborted, got;
    int          ab_at, n;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      nd   = ($urandom_range(0, 7) == 0);
      word = 10'($urandom_range(0, 15));
      adr  = {nd ? 8'h30 : DEC, 12'($urandom), word, 2'($urandom)};
      wb_set(1'b1, adr, 1'($urandom), 4'($urandom), $urandom);
      if (nd) begin
        repeat (3) @(negedge clk);
      end else begin
        abort = ($urandom_range(0, 5) == 0);
        ab_at = $urandom_range(1, 14);
        aborted = 1'b0; got = 1'b0; n = 0;
        while (!got && !aborted && n < 60) begin
          @(negedge clk);
          n++;
          if (wbs_ack_o) got = 1'b1;
          else if (abort && n == ab_at) aborted = 1'b1;
        end
        if (!got && !aborted) check("wb_rand_timeout", 32'(got), 32'd1);
      end
      wb_set(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    end
  endtask

  task automatic dma_random();
    int          lat;
    logic [31:0] rd;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      dma_set(1'b1, AW'($urandom_range(0, 15)), 1'($urandom), 4'($urandom), $urandom);
      wait_ack(1'b1, 60, lat, rd);
      dma_set(1'b0, '0, 1'b0, 4'h0, 32'h0);
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic [31:0] dma_wdat;
    logic        got, who;
    int          n;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy",   32'(busy_o),    32'd0);
    check("rst_owner",  32'(owner_o),   32'd1);
    check("rst_en",     32'(bram_en_o), 32'd0);
    check("rst_wbdat",  wbs_dat_o,      32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Wishbone write: window cycles 1..11, ack in cycle 12
    @(negedge clk);
    wb_set(1'b1, 32'h3800_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= D + 1) begin
        check("wr_we", 32'(bram_we_o), 32'hF);
        check("wr_a",  bram_a_o,       32'h10);
        check("wr_ack_early", 32'(wbs_ack_o), 32'd0);
      end else begin
        check("wr_ack",     32'(wbs_ack_o), 32'd1);
        check("wr_dma_ack", 32'(dma_ack_o), 32'd0);
        wb_set(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      end
    end
    @(negedge clk);
    check("wr_ack_pulse", 32'(wbs_ack_o), 32'd0);

    // Wishbone read-back
    @(negedge clk);
    wb_set(1'b1, 32'h3800_0010, 1'b0, 4'hF, 32'h0);
    wait_ack(1'b0, 40, lat, rd);
    wb_set(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    check("rd_latency", 32'(lat), 32'd12);
    check("rd_data",    rd,       32'hDEAD_BEEF);

    // Non-decoded window: never served
    @(negedge clk);
    wb_set(1'b1, 32'h3000_0000, 1'b1, 4'hF, 32'h1234_5678);
    repeat (50) begin
      @(negedge clk);
      check("nd_en",  32'(bram_en_o), 32'd0);
      check("nd_ack", 32'(wbs_ack_o), 32'd0);
    end
    wb_set(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

    // DMA write to top word, partial byte strobes
    dma_wdat = $urandom;
    @(negedge clk);
    dma_set(1'b1, 10'h3FF, 1'b1, 4'b0011, dma_wdat);
    @(negedge clk);
    check("dma_a",  bram_a_o,       32'hFFC);
    check("dma_we", 32'(bram_we_o), 32'h3);
    wait_ack(1'b1, 40, lat, rd);
    dma_set(1'b0, '0, 1'b0, 4'h0, 32'h0);
    check("dma_latency", 32'(lat), 32'd11);

    // Wishbone address wraps within the BRAM
    @(negedge clk);
    wb_set(1'b1, 32'h3800_1000, 1'b1, 4'hF, 32'h0BAD_F00D);
    @(negedge clk);
    check("wrap_a", bram_a_o, 32'h0);
    wait_ack(1'b0, 40, lat, rd);
    wb_set(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

    // Wishbone abort: cyc dropped in window cycle 5
    @(negedge clk);
    wb_set(1'b1, 32'h3800_0020, 1'b1, 4'hF, 32'hA5A5_A5A5);
    repeat (5) @(negedge clk);
    wb_set(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    @(negedge clk);
    check("abort_idle", 32'(busy_o), 32'd0);
    repeat (20) begin
      @(negedge clk);
      check("abort_noack", 32'(wbs_ack_o), 32'd0);
    end
    // The repeated write already landed before the abort.
    wb_set(1'b1, 32'h3800_0020, 1'b0, 4'hF, 32'h0);
    wait_ack(1'b0, 40, lat, rd);
    wb_set(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    check("abort_commit", rd, 32'hA5A5_A5A5);

    // Reset in cycle 6 of a DMA access, then a clean DMA read
    @(negedge clk);
    dma_set(1'b1, 10'h3FF, 1'b0, 4'h0, 32'h0);
    repeat (6) @(negedge clk);
    dma_set(1'b0, '0, 1'b0, 4'h0, 32'h0);
    pulse_reset();
    @(negedge clk);
    check("rstmid_noack", 32'(dma_ack_o), 32'd0);
    dma_set(1'b1, 10'h3FF, 1'b0, 4'h0, 32'h0);
    wait_ack(1'b1, 40, lat, rd);
    dma_set(1'b0, '0, 1'b0, 4'h0, 32'h0);
    check("rstmid_latency", 32'(lat), 32'd12);
    check("rstmid_data",    rd,       {16'h0, dma_wdat[15:0]});

    // Contention straight after reset: grants alternate WB, DMA, ...
    @(negedge clk);
    pulse_reset();
    @(negedge clk);
    wb_set(1'b1, 32'h3800_0010, 1'b0, 4'hF, 32'h0);
    dma_set(1'b1, 10'h3FF, 1'b0, 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      got = 1'b0; n = 0;
      while (!got && n < 40) begin
        @(negedge clk);
        n++;
        if (wbs_ack_o || dma_ack_o) got = 1'b1;
      end
      if (!got) begin
        check("rr_timeout", 32'(got), 32'd1);
      end else begin
        who = dma_ack_o;
        check("rr_order",  32'(who),                   32'(i % 2));
        check("rr_owner",  32'(owner_o),               32'(i % 2));
        check("rr_single", 32'(wbs_ack_o & dma_ack_o), 32'd0);
        if (who) dma_req_i = 1'b0;
        else begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
        @(negedge clk);
        if (i < 6) begin
          if (who) dma_req_i = 1'b1;
          else begin wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; end
        end
      end
    end
    wb_set(1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    dma_set(1'b0, '0, 1'b0, 4'h0, 32'h0);

    // Randomized traffic from both masters
    fork
      wb_random();
      dma_random();
    join
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
